// File: rtl/bgpu_ddr3_pkg.sv
// Shared types for the BGPU-to-DDR3 native interface adapter.
// Widths match one BL8 burst on a 32-bit DDR3 bus at 1:4 clocking.
package bgpu_ddr3_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 256;
    localparam int STRB_W     = DATA_W / 8;
    localparam int DDR_ADDR_W = 28;

    localparam logic [2:0] DDR3_CMD_WR = 3'b000;
    localparam logic [2:0] DDR3_CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_RESP
    } ddr3_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } ddr3_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } ddr3_rsp_t;

endpackage

// File: rtl/bgpu_ddr3_native_adapter.sv
// One-transaction-at-a-time bridge from the SoC request/response stream
// to the Gowin DDR3 controller native port, with a read timeout.
module bgpu_ddr3_native_adapter
    import bgpu_ddr3_pkg::*;
#(
    parameter int AddrWidth    = ADDR_W,
    parameter int DataWidth    = DATA_W,
    parameter int DdrAddrWidth = DDR_ADDR_W,
    parameter int RdTimeout    = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    init_done_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [DataWidth/8-1:0]  req_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DataWidth-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    input  logic                    ctrl_cmd_ready_i,
    output logic                    ctrl_cmd_en_o,
    output logic [2:0]              ctrl_cmd_o,
    output logic [DdrAddrWidth-1:0] ctrl_addr_o,
    input  logic                    ctrl_wr_data_rdy_i,
    output logic                    ctrl_wr_data_en_o,
    output logic [DataWidth-1:0]    ctrl_wr_data_o,
    output logic                    ctrl_wr_data_end_o,
    output logic [DataWidth/8-1:0]  ctrl_wr_data_mask_o,
    input  logic                    ctrl_rd_data_valid_i,
    input  logic                    ctrl_rd_data_end_i,
    input  logic [DataWidth-1:0]    ctrl_rd_data_i,
    output logic                    busy_o
);

    localparam int CntW = $clog2(RdTimeout);

    ddr3_state_e     state;
    ddr3_state_e     state_nxt;
    ddr3_req_t       req_q;
    ddr3_rsp_t       rsp_q;
    logic [CntW-1:0] cnt;
    logic            req_fire;
    logic            rd_timeout;

    assign req_ready_o = init_done_i && !rst_i && (state == ST_IDLE);
    assign req_fire    = req_valid_i && req_ready_o;
    assign rd_timeout  = (cnt == CntW'(RdTimeout - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (req_fire) state_nxt = ST_CMD;
            ST_CMD: begin
                if (ctrl_cmd_ready_i) begin
                    state_nxt = req_q.we ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: if (ctrl_wr_data_rdy_i) state_nxt = ST_RESP;
            ST_RDATA: begin
                if (ctrl_rd_data_valid_i || rd_timeout) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:  if (rsp_ready_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q <= '0;
            rsp_q <= '0;
            cnt   <= '0;
        end else begin
            if (req_fire) begin
                req_q <= '{we: req_we_i, addr: req_addr_i,
                           wdata: req_wdata_i, strb: req_strb_i};
                rsp_q <= '0;
            end
            if (state == ST_CMD) begin
                cnt <= '0;
            end
            // Valid beats the timeout when both land in the same cycle.
            if (state == ST_RDATA) begin
                cnt <= cnt + CntW'(1);
                if (ctrl_rd_data_valid_i) begin
                    rsp_q.rdata <= ctrl_rd_data_i;
                end else if (rd_timeout) begin
                    rsp_q.err <= 1'b1;
                end
            end
        end
    end

    assign busy_o              = (state != ST_IDLE);
    assign ctrl_cmd_en_o       = (state == ST_CMD);
    assign ctrl_cmd_o          = (ctrl_cmd_en_o && !req_q.we) ? DDR3_CMD_RD
                                                              : DDR3_CMD_WR;
    assign ctrl_addr_o         = {req_q.addr[DdrAddrWidth+1:5], 3'b000};
    assign ctrl_wr_data_en_o   = (state == ST_WDATA);
    assign ctrl_wr_data_end_o  = ctrl_wr_data_en_o;
    assign ctrl_wr_data_o      = req_q.wdata;
    assign ctrl_wr_data_mask_o = ctrl_wr_data_en_o ? ~req_q.strb : '0;
    assign rsp_valid_o         = (state == ST_RESP);
    assign rsp_rdata_o         = rsp_q.rdata;
    assign rsp_err_o           = rsp_q.err;

    logic unused_bits;
    assign unused_bits = ^{ctrl_rd_data_end_i,
                           req_q.addr[AddrWidth-1:DdrAddrWidth+2],
                           req_q.addr[4:0]};

endmodule

// File: tb/tb_bgpu_ddr3_native_adapter.sv
// Directed bench for bgpu_ddr3_native_adapter with a short read timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bgpu_ddr3_native_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_done;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic [31:0]  req_strb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_rdata;
    logic         rsp_err;
    logic         ctrl_cmd_ready;
    logic         ctrl_cmd_en;
    logic [2:0]   ctrl_cmd;
    logic [27:0]  ctrl_addr;
    logic         ctrl_wr_data_rdy;
    logic         ctrl_wr_data_en;
    logic [255:0] ctrl_wr_data;
    logic         ctrl_wr_data_end;
    logic [31:0]  ctrl_wr_data_mask;
    logic         ctrl_rd_data_valid;
    logic         ctrl_rd_data_end;
    logic [255:0] ctrl_rd_data;
    logic         busy;

    int checks = 0;
    int failures = 0;

    logic [255:0] pat_w1;
    logic [255:0] pat_a5;
    logic [255:0] pat_ff;
    logic [255:0] pat_w2;
    logic [255:0] pat_r2;
    logic [255:0] pat_r3;

    always #5 clk = ~clk;

    bgpu_ddr3_native_adapter #(.RdTimeout(16)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .init_done_i          (init_done),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_we_i             (req_we),
        .req_addr_i           (req_addr),
        .req_wdata_i          (req_wdata),
        .req_strb_i           (req_strb),
        .rsp_valid_o          (rsp_valid),
        .rsp_ready_i          (rsp_ready),
        .rsp_rdata_o          (rsp_rdata),
        .rsp_err_o            (rsp_err),
        .ctrl_cmd_ready_i     (ctrl_cmd_ready),
        .ctrl_cmd_en_o        (ctrl_cmd_en),
        .ctrl_cmd_o           (ctrl_cmd),
        .ctrl_addr_o          (ctrl_addr),
        .ctrl_wr_data_rdy_i   (ctrl_wr_data_rdy),
        .ctrl_wr_data_en_o    (ctrl_wr_data_en),
        .ctrl_wr_data_o       (ctrl_wr_data),
        .ctrl_wr_data_end_o   (ctrl_wr_data_end),
        .ctrl_wr_data_mask_o  (ctrl_wr_data_mask),
        .ctrl_rd_data_valid_i (ctrl_rd_data_valid),
        .ctrl_rd_data_end_i   (ctrl_rd_data_end),
        .ctrl_rd_data_i       (ctrl_rd_data),
        .busy_o               (busy)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_cmd_en"}, ctrl_cmd_en, 0);
        check({tag, "_cmd"}, ctrl_cmd, 0);
        check({tag, "_addr"}, ctrl_addr, 0);
        check({tag, "_wd_en"}, ctrl_wr_data_en, 0);
        check({tag, "_wd_end"}, ctrl_wr_data_end, 0);
        check({tag, "_wd"}, ctrl_wr_data, 0);
        check({tag, "_mask"}, ctrl_wr_data_mask, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic send_req(input logic we, input logic [31:0] addr,
                            input logic [255:0] wdata,
                            input logic [31:0] strb);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        check("req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("req_taken", busy, 1);
    endtask

    task automatic accept_cmd(input logic [2:0] cmd, input logic [27:0] addr,
                              input int delay);
        check("cmd_en", ctrl_cmd_en, 1);
        check("cmd", ctrl_cmd, cmd);
        check("cmd_addr", ctrl_addr, addr);
        check("wd_early", ctrl_wr_data_en, 0);
        repeat (delay) begin
            tick();
            check("cmd_en_hold", ctrl_cmd_en, 1);
            check("cmd_hold", ctrl_cmd, cmd);
            check("cmd_addr_hold", ctrl_addr, addr);
            check("wd_early_hold", ctrl_wr_data_en, 0);
        end
        ctrl_cmd_ready = 1'b1;
        tick();
        ctrl_cmd_ready = 1'b0;
        check("cmd_en_drop", ctrl_cmd_en, 0);
    endtask

    task automatic wr_beat(input logic [255:0] data, input logic [31:0] mask,
                           input int delay);
        check("wd_en", ctrl_wr_data_en, 1);
        check("wd_end", ctrl_wr_data_end, 1);
        check("wd", ctrl_wr_data, data);
        check("wd_mask", ctrl_wr_data_mask, mask);
        repeat (delay) begin
            tick();
            check("wd_en_hold", ctrl_wr_data_en, 1);
            check("wd_hold", ctrl_wr_data, data);
            check("wd_mask_hold", ctrl_wr_data_mask, mask);
        end
        ctrl_wr_data_rdy = 1'b1;
        tick();
        ctrl_wr_data_rdy = 1'b0;
        check("wd_en_drop", ctrl_wr_data_en, 0);
    endtask

    task automatic take_rsp(input logic err, input logic [255:0] rdata,
                            input int hold);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, err);
        check("rsp_rdata", rsp_rdata, rdata);
        repeat (hold) begin
            tick();
            check("rsp_valid_hold", rsp_valid, 1);
            check("rsp_err_hold", rsp_err, err);
            check("rsp_rdata_hold", rsp_rdata, rdata);
            check("no_req_in_resp", req_ready, 0);
        end
        rsp_ready = 1'b1;
        check("no_req_in_hs", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("idle", busy, 0);
    endtask

    task automatic rd_beat(input int wait_cycles, input logic [255:0] data);
        repeat (wait_cycles) begin
            tick();
            check("rd_wait", rsp_valid, 0);
        end
        ctrl_rd_data_valid = 1'b1;
        ctrl_rd_data_end   = 1'b1;
        ctrl_rd_data       = data;
        tick();
        ctrl_rd_data_valid = 1'b0;
        ctrl_rd_data_end   = 1'b0;
        ctrl_rd_data       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_w1 = {8{32'hDEADBEEF}};
        pat_a5 = {32{8'hA5}};
        pat_ff = {32{8'hFF}};
        pat_w2 = {16{16'h1234}};
        pat_r2 = {4{64'h0123_4567_89AB_CDEF}};
        pat_r3 = {8{32'h5A5A_0F0F}};

        rst = 1'b1;
        init_done = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_strb = '0;
        rsp_ready = 1'b0;
        ctrl_cmd_ready = 1'b0;
        ctrl_wr_data_rdy = 1'b0;
        ctrl_rd_data_valid = 1'b0;
        ctrl_rd_data_end = 1'b0;
        ctrl_rd_data = '0;

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Calibration not complete: nothing may be accepted.
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 32'h0000_0120;
        for (int i = 0; i < 20; i++) begin
            check("no_init_ready", req_ready, 0);
            tick();
            check("no_init_cmd", ctrl_cmd_en, 0);
        end
        req_valid = 1'b0;
        init_done = 1'b1;
        tick();

        send_req(1'b1, 32'h0000_0120, pat_w1, 32'hFFFF_FFFF);
        accept_cmd(3'b000, 28'h000_0048, 3);
        wr_beat(pat_w1, 32'h0, 1);
        take_rsp(1'b0, 256'h0, 0);

        send_req(1'b0, 32'h0000_0040, '0, '0);
        accept_cmd(3'b001, 28'h000_0010, 0);
        rd_beat(12, pat_a5);
        take_rsp(1'b0, pat_a5, 0);

        // Timeout: 16 cycles in RDATA with no valid.
        send_req(1'b0, 32'h0000_0080, '0, '0);
        accept_cmd(3'b001, 28'h000_0020, 0);
        repeat (15) tick();
        check("to_early", rsp_valid, 0);
        tick();
        check("to_valid", rsp_valid, 1);
        check("to_err", rsp_err, 1);
        check("to_rdata", rsp_rdata, 0);
        ctrl_rd_data_valid = 1'b1;
        ctrl_rd_data = pat_ff;
        tick();
        take_rsp(1'b1, 256'h0, 0);
        tick();
        ctrl_rd_data_valid = 1'b0;
        ctrl_rd_data = '0;
        check("late_valid_idle", busy, 0);
        check("late_valid_rsp", rsp_valid, 0);

        // Back-to-back write then read with a stalled response.
        send_req(1'b1, 32'hC000_3FE0, pat_w2, 32'h0000_FFFF);
        accept_cmd(3'b000, 28'h000_0FF8, 1);
        wr_beat(pat_w2, 32'hFFFF_0000, 2);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 32'h0000_1000;
        take_rsp(1'b0, 256'h0, 5);
        send_req(1'b0, 32'h0000_1000, '0, '0);
        accept_cmd(3'b001, 28'h000_0400, 0);
        rd_beat(2, pat_r2);
        take_rsp(1'b0, pat_r2, 0);

        // Reset in the middle of a stalled write beat.
        send_req(1'b1, 32'h0000_0200, pat_w1, 32'hFFFF_FFFF);
        accept_cmd(3'b000, 28'h000_0080, 0);
        check("pre_rst_wd_en", ctrl_wr_data_en, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);

        send_req(1'b0, 32'h0000_0400, '0, '0);
        accept_cmd(3'b001, 28'h000_0100, 2);
        rd_beat(3, pat_r3);
        take_rsp(1'b0, pat_r3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
